// File: rtl/alu_issue_wb_pkg.sv
// Shared decode constants for the ALU issue/write-back stage.
package alu_issue_wb_pkg;

  localparam int AW = 4;

  // Instruction field positions.
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int EXT_LSB = 4;
  localparam int RS_LSB  = 0;

  // Flag bit indices within {C,L,F,Z,N}.
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // Primary opcodes.
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_CMP   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_MOVI  = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_RSHI  = 4'b1110;

  // Register-format extension codes.
  localparam logic [3:0] EXT_NOP  = 4'b0000;
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_NOT  = 4'b0100;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDU = 4'b0110;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_MOV  = 4'b1101;

  // Decoded view of a 16-bit instruction word.
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ext;
    logic [3:0] rs;
  } instr_t;

endpackage

// File: rtl/alu_issue_wb_regfile.sv
// 16x16 register file: two async read ports, one debug read port,
// one synchronous write port, asynchronous active-low clear.
module regfile_16x16
  import alu_issue_wb_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o,
  input  logic [AW-1:0] dbg_raddr_i,
  output logic [DW-1:0] dbg_rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i
);

  logic [DW-1:0] mem_q [NREGS];

  assign rdata_a_o   = mem_q[raddr_a_i];
  assign rdata_b_o   = mem_q[raddr_b_i];
  assign dbg_rdata_o = mem_q[dbg_raddr_i];

  // Storage: cleared on reset, one write per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/alu_issue_wb.sv
// Operand issue and write-back around a combinational ALU: decode,
// register read with result forwarding, registered ALU inputs, and
// write-back of the result and status flags one edge later.
module alu_issue_wb
  import alu_issue_wb_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  input  logic          hold,
  output logic [DW-1:0] alu_A,
  output logic [DW-1:0] alu_B,
  output logic [3:0]    alu_opcode,
  output logic [3:0]    alu_opext,
  input  logic [DW-1:0] alu_S,
  input  logic [4:0]    alu_CLFZN,
  output logic [4:0]    psr,
  output logic          wb_en,
  output logic [3:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  input  logic [3:0]    dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);

  function automatic logic [DW-1:0] sext8(input logic [7:0] v);
    return {{(DW-8){v[7]}}, v};
  endfunction

  function automatic logic [DW-1:0] zext8(input logic [7:0] v);
    return {{(DW-8){1'b0}}, v};
  endfunction

  instr_t        dec;
  logic          accept;
  logic [DW-1:0] rf_rd, rf_rs, opnd_rd, opnd_rs;
  logic [DW-1:0] a_d, b_d, a_q, b_q;
  logic [3:0]    op_q, ext_q, rdest_q;
  logic          ex_valid_q;
  logic [4:0]    psr_q;
  logic          psr_upd;

  assign dec         = instr_t'(instr);
  assign instr_ready = rst_n & ~hold;
  assign accept      = instr_valid & instr_ready;

  regfile_16x16 #(.NREGS(NREGS), .DW(DW)) u_rf (
    .clk         (clk),
    .rst_n       (rst_n),
    .raddr_a_i   (dec.rd),
    .rdata_a_o   (rf_rd),
    .raddr_b_i   (dec.rs),
    .rdata_b_o   (rf_rs),
    .dbg_raddr_i (dbg_raddr),
    .dbg_rdata_o (dbg_rdata),
    .we_i        (wb_en),
    .waddr_i     (wb_addr),
    .wdata_i     (alu_S)
  );

  // Forward the result being written this cycle to a dependent reader.
  assign opnd_rd = (wb_en && (wb_addr == dec.rd)) ? alu_S : rf_rd;
  assign opnd_rs = (wb_en && (wb_addr == dec.rs)) ? alu_S : rf_rs;

  // Operand selection per opcode and extension.
  always_comb begin
    a_d = opnd_rd;
    b_d = opnd_rs;
    case (dec.op)
      OP_REG: begin
        if (dec.ext == EXT_MOV || dec.ext == EXT_NOT) begin
          a_d = opnd_rs;
          b_d = '0;
        end
      end
      OP_ADDI, OP_SUBI, OP_CMPI: b_d = sext8({dec.ext, dec.rs});
      OP_ADDUI:                  b_d = zext8({dec.ext, dec.rs});
      OP_MOVI: begin
        a_d = zext8({dec.ext, dec.rs});
        b_d = '0;
      end
      OP_RSHI:                   b_d = '0;
      default: ;
    endcase
  end

  // Execute registers: load on accept, otherwise present a NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      rdest_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      ext_q      <= '0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      rdest_q    <= dec.rd;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= dec.op;
      ext_q      <= dec.ext;
    end else begin
      ex_valid_q <= 1'b0;
      rdest_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      ext_q      <= '0;
    end
  end

  assign alu_A      = a_q;
  assign alu_B      = b_q;
  assign alu_opcode = op_q;
  assign alu_opext  = ext_q;

  // Compares and register-format NOP produce no register result.
  assign wb_en   = ex_valid_q &
                   ~((op_q == OP_CMP) || (op_q == OP_CMPI) ||
                     ((op_q == OP_REG) && (ext_q == EXT_NOP)));
  assign wb_addr = rdest_q;
  assign wb_data = alu_S;

  // Only arithmetic and compare ops change the status flags.
  assign psr_upd = ex_valid_q &
                   (((op_q == OP_REG) &&
                     ((ext_q == EXT_ADD) || (ext_q == EXT_ADDU) || (ext_q == EXT_SUB))) ||
                    (op_q == OP_ADDI) || (op_q == OP_ADDUI) || (op_q == OP_SUBI) ||
                    (op_q == OP_CMP)  || (op_q == OP_CMPI));

  // Processor status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       psr_q <= '0;
    else if (psr_upd) psr_q <= alu_CLFZN;
  end

  assign psr = psr_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        hold;
  logic [15:0] alu_A, alu_B;
  logic [3:0]  alu_opcode, alu_opext;
  logic [15:0] alu_S;
  logic [4:0]  alu_CLFZN;
  logic [4:0]  psr;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  dbg_raddr;
  logic [15:0] dbg_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_wb dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .hold(hold), .alu_A(alu_A), .alu_B(alu_B),
    .alu_opcode(alu_opcode), .alu_opext(alu_opext), .alu_S(alu_S),
    .alu_CLFZN(alu_CLFZN), .psr(psr), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  // Reference ALU: flags {C,L,F,Z,N}.
  logic [16:0] sum;
  always_comb begin
    alu_S     = 16'h0000;
    alu_CLFZN = 5'b00000;
    sum       = 17'h0;
    case (alu_opcode)
      4'b0000: begin
        case (alu_opext)
          4'b0101, 4'b0110: begin
            sum = {1'b0, alu_A} + {1'b0, alu_B};
            alu_S = sum[15:0];
            alu_CLFZN[4] = sum[16];
            if (alu_opext == 4'b0101)
              alu_CLFZN[2] = (alu_A[15] == alu_B[15]) && (sum[15] != alu_A[15]);
          end
          4'b1001: begin
            alu_S = alu_A - alu_B;
            alu_CLFZN[4] = alu_A < alu_B;
            alu_CLFZN[2] = (alu_A[15] != alu_B[15]) && (alu_S[15] != alu_A[15]);
          end
          4'b1101: alu_S = alu_A;
          4'b0100: alu_S = ~alu_A;
          4'b0001: alu_S = alu_A & alu_B;
          4'b0010: alu_S = alu_A | alu_B;
          4'b0011: alu_S = alu_A ^ alu_B;
          default: alu_S = 16'h0000;
        endcase
      end
      4'b0101, 4'b0110: begin
        sum = {1'b0, alu_A} + {1'b0, alu_B};
        alu_S = sum[15:0];
        alu_CLFZN[4] = sum[16];
        if (alu_opcode == 4'b0101)
          alu_CLFZN[2] = (alu_A[15] == alu_B[15]) && (sum[15] != alu_A[15]);
      end
      4'b1001: begin
        alu_S = alu_A - alu_B;
        alu_CLFZN[4] = alu_A < alu_B;
        alu_CLFZN[2] = (alu_A[15] != alu_B[15]) && (alu_S[15] != alu_A[15]);
      end
      4'b0011, 4'b1011: begin
        alu_CLFZN[3] = alu_A < alu_B;
        alu_CLFZN[1] = alu_A == alu_B;
        alu_CLFZN[0] = $signed(alu_A) < $signed(alu_B);
      end
      4'b1000: alu_S = alu_A;
      4'b1110: alu_S = alu_A >> 1;
      default: alu_S = 16'h0000;
    endcase
  end

  typedef struct {
    logic [15:0] ins;
    logic [15:0] a;
    logic [15:0] b;
    logic        wb;
    logic [3:0]  rg;
    logic [15:0] val;
    logic [4:0]  ps;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
    dbg_raddr = a;
    #1;
    v = dbg_rdata;
  endtask

  task automatic issue(input logic [15:0] w);
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  logic [15:0] v;

  initial begin
    //            instr     A         B         wb    reg   value     psr
    vecs[0]  = '{16'h8105, 16'h0005, 16'h0000, 1'b1, 4'd1, 16'h0005, 5'b00000};
    vecs[1]  = '{16'h8203, 16'h0003, 16'h0000, 1'b1, 4'd2, 16'h0003, 5'b00000};
    vecs[2]  = '{16'h0152, 16'h0005, 16'h0003, 1'b1, 4'd1, 16'h0008, 5'b00000};
    vecs[3]  = '{16'h8380, 16'h0080, 16'h0000, 1'b1, 4'd3, 16'h0080, 5'b00000};
    vecs[4]  = '{16'h5380, 16'h0080, 16'hFF80, 1'b1, 4'd3, 16'h0000, 5'b10000};
    vecs[5]  = '{16'h8502, 16'h0002, 16'h0000, 1'b1, 4'd5, 16'h0002, 5'b10000};
    vecs[6]  = '{16'hB502, 16'h0002, 16'h0002, 1'b0, 4'd5, 16'h0002, 5'b00010};
    vecs[7]  = '{16'h0192, 16'h0008, 16'h0003, 1'b1, 4'd1, 16'h0005, 5'b00000};
    vecs[8]  = '{16'h06D1, 16'h0005, 16'h0000, 1'b1, 4'd6, 16'h0005, 5'b00000};
    vecs[9]  = '{16'h6680, 16'h0005, 16'h0080, 1'b1, 4'd6, 16'h0085, 5'b00000};
    vecs[10] = '{16'h9605, 16'h0085, 16'h0005, 1'b1, 4'd6, 16'h0080, 5'b00000};
    vecs[11] = '{16'h57FF, 16'h0000, 16'hFFFF, 1'b1, 4'd7, 16'hFFFF, 5'b00000};
    vecs[12] = '{16'h3502, 16'h0002, 16'h0003, 1'b0, 4'd5, 16'h0002, 5'b01001};

    rst_n = 1'b0; hold = 1'b0; instr_valid = 1'b0; instr = 16'h0000; dbg_raddr = 4'd0;
    #3;
    check("rst ready", instr_ready, 0);
    check("rst alu_A", alu_A, 0);
    check("rst opcode", alu_opcode, 0);
    check("rst psr", psr, 0);
    check("rst wb_en", wb_en, 0);
    rd_reg(4'd0, v); check("rst r0", v, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready after rst", instr_ready, 1);

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].ins);
      check($sformatf("v%0d alu_A", i), alu_A, vecs[i].a);
      check($sformatf("v%0d alu_B", i), alu_B, vecs[i].b);
      check($sformatf("v%0d wb_en", i), wb_en, vecs[i].wb);
      @(posedge clk);
      #1;
      rd_reg(vecs[i].rg, v);
      check($sformatf("v%0d reg", i), v, vecs[i].val);
      check($sformatf("v%0d psr", i), psr, vecs[i].ps);
    end

    // Back-to-back MOVI r4 / ADDUI r4 with forwarding.
    @(negedge clk);
    instr = 16'h847F; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = 16'h6401;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("fwd alu_A", alu_A, 16'h007F);
    check("fwd alu_B", alu_B, 16'h0001);
    @(posedge clk); #1;
    rd_reg(4'd4, v); check("fwd r4", v, 16'h0080);

    // Same register in both fields: MOVI r8,0x11 then ADD r8,r8.
    @(negedge clk);
    instr = 16'h8811; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = 16'h0858;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("fwd2 alu_A", alu_A, 16'h0011);
    check("fwd2 alu_B", alu_B, 16'h0011);
    @(posedge clk); #1;
    rd_reg(4'd8, v); check("fwd2 r8", v, 16'h0022);

    // Debug port shows the register file, not the pending result.
    issue(16'h8933);
    check("dbg wb_data", wb_data, 16'h0033);
    check("dbg wb_addr", wb_addr, 4'd9);
    rd_reg(4'd9, v); check("dbg r9 pre", v, 16'h0000);
    @(posedge clk); #1;
    rd_reg(4'd9, v); check("dbg r9 post", v, 16'h0033);

    // Hold after SUB r2,r1: SUB completes, then NOPs.
    issue(16'h0291);
    hold = 1'b1; instr = 16'h8A44; instr_valid = 1'b1;
    #1;
    check("hold ready", instr_ready, 0);
    @(posedge clk); #1;
    check("hold opcode", alu_opcode, 0);
    check("hold opext", alu_opext, 0);
    check("hold wb_en", wb_en, 0);
    rd_reg(4'd2, v); check("hold r2", v, 16'hFFFE);
    check("hold psr", psr, 5'b10000);
    @(posedge clk); #1;
    check("hold psr2", psr, 5'b10000);
    rd_reg(4'd10, v); check("hold r10", v, 16'h0000);
    hold = 1'b0; instr_valid = 1'b0;

    // Reset right after ADD r1,r2 issues.
    issue(16'h0152);
    check("pre-rst wb_en", wb_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst alu_A", alu_A, 0);
    check("arst alu_B", alu_B, 0);
    check("arst opcode", alu_opcode, 0);
    check("arst opext", alu_opext, 0);
    check("arst wb_en", wb_en, 0);
    check("arst psr", psr, 0);
    check("arst ready", instr_ready, 0);
    @(posedge clk); #1;
    for (int r = 0; r < 16; r++) begin
      rd_reg(r[3:0], v);
      check($sformatf("arst r%0d", r), v, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
